sram_1rw_masked_init: RTL

- Parametrised single-port (1RW) synchronous RAM macro model with a sub-word write mask. Next generation of the fixed-geometry masked array models.
- Adds configurable depth, width and mask granularity, and a configurable read-pipeline latency with a valid strobe.
- Adds a hardware init engine that sweeps every entry to a known value after reset or on request, with a ready/busy handshake.
- Used as the backing store for cache tag/data arrays and other SRAM-mapped structures.

---
 rtl/sram_1rw_masked_init_if.sv | 30 +++
 rtl/sram_1rw_masked_init.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sram_1rw_masked_init_if.sv
// Access/init bundle for the masked 1RW SRAM model.
// Latency: none (wires only).
// Backpressure: master may present a request only while RW0_ready is high; others are dropped.
interface sram_1rw_masked_init_if #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 152,
  parameter int MASK_SEG = 8
);
  logic [ADDR_W-1:0]   RW0_addr;
  logic                RW0_en;
  logic                RW0_wmode;
  logic [MASK_SEG-1:0] RW0_wmask;
  logic [DATA_W-1:0]   RW0_wdata;
  logic [DATA_W-1:0]   RW0_rdata;
  logic                RW0_rvalid;
  logic                RW0_rerr;
  logic                RW0_ready;
  logic                init_req;
  logic                init_busy;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, init_req,
    input  RW0_rdata, RW0_rvalid, RW0_rerr, RW0_ready, init_busy
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, init_req,
    output RW0_rdata, RW0_rvalid, RW0_rerr, RW0_ready, init_busy
  );
endinterface

// File: rtl/sram_1rw_masked_init.sv
// Parametrised 1RW SRAM model with per-lane write mask and a hardware init sweep.
// Latency: read data + rvalid RD_LAT cycles after accept; writes land at the accept edge.
// Backpressure: RW0_ready low during the init sweep; requests seen then are dropped.
module sram_1rw_masked_init #(
  parameter int              ADDR_W    = 9,
  parameter int              DEPTH     = 512,
  parameter int              DATA_W    = 152,
  parameter int              MASK_GRAN = 19,
  parameter int              RD_LAT    = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic                   RW0_clk,
  input logic                   RW0_rst_n,
  sram_1rw_masked_init_if.slave rw0
);
  localparam int MASK_SEG = DATA_W / MASK_GRAN;
  // Widened by one bit so DEPTH == 2^ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  cnt_q;
  logic               ready_q;
  logic               busy_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [RD_LAT-1:0]  vld_q;
  logic [RD_LAT-1:0]  err_q;
  logic [DATA_W-1:0]  dat_q [RD_LAT];

  logic               acc;
  logic               in_range;
  logic               wr_acc;
  logic               rd_acc;
  logic [ADDR_W-1:0]  rd_idx;
  logic [DATA_W-1:0]  rd_dat_d;

  // Request qualification; out-of-range reads use a safe index and return zero.
  always_comb begin
    acc      = rw0.RW0_en & ready_q;
    in_range = ({1'b0, rw0.RW0_addr} < DEPTH_L);
    wr_acc   = acc & rw0.RW0_wmode & in_range;
    rd_acc   = acc & ~rw0.RW0_wmode;
    rd_idx   = in_range ? rw0.RW0_addr : '0;
    rd_dat_d = in_range ? mem[rd_idx] : '0;
  end

  // Init/idle control: sweep counter and registered ready/busy flags.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          // An access in this same cycle is still accepted (ready_q is high).
          if (rw0.init_req) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Array write port: the sweep owns it while in INIT (ready is low, so no access competes).
  always_ff @(posedge RW0_clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr_acc) begin
      for (int i = 0; i < MASK_SEG; i++) begin
        if (rw0.RW0_wmask[i]) begin
          mem[rw0.RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= rw0.RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Read pipeline: data is sampled at the accept edge; stages only load on a valid so the last holds.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        dat_q[0] <= rd_dat_d;
        err_q[0] <= ~in_range;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
          err_q[k] <= err_q[k-1];
        end
      end
    end
  end

  assign rw0.RW0_rdata  = dat_q[RD_LAT-1];
  assign rw0.RW0_rvalid = vld_q[RD_LAT-1];
  assign rw0.RW0_rerr   = vld_q[RD_LAT-1] & err_q[RD_LAT-1];
  assign rw0.RW0_ready  = ready_q;
  assign rw0.init_busy  = busy_q;
endmodule
